// File: rtl/gray_tracker.sv
// Gray-code tracker: decodes the counter's Gray output, checks for single-step moves,
// counts max->0 wraps and latches Overflow. Define GRAY_BIDIR_EN to also accept decrements.
module gray_tracker #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Gray_in,
    input  logic             Overflow_in,
    output logic [WIDTH-1:0] Bin_out,
    output logic             Bin_valid,
    output logic [CNT_W-1:0] Wrap_count,
    output logic             Ovf_seen,
    output logic             Step_err
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] bin_n;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;

    // Each binary bit is the XOR of the Gray bits at and above it.
    always_comb begin
        bin_n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_n[i] = ^(Gray_in >> i);
        end
    end

    assign prev_inc = prev_q + WIDTH'(1);
    assign prev_dec = prev_q - WIDTH'(1);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        valid_d = valid_q;
        wrap_d  = wrap_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        if (Clear) begin
            state_d = ST_SYNC;
            valid_d = 1'b0;
            wrap_d  = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else if (En) begin
            if (Overflow_in) begin
                ovf_d = 1'b1;
            end
            case (state_q)
                ST_SYNC: begin
                    prev_d  = bin_n;
                    bin_d   = bin_n;
                    valid_d = 1'b1;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (bin_n == prev_q) begin
                        // Repeated code: legal hold, nothing changes.
                    end else if (bin_n == prev_inc) begin
                        prev_d = bin_n;
                        bin_d  = bin_n;
                        if (prev_q == '1 && wrap_q != '1) begin
                            wrap_d = wrap_q + CNT_W'(1);
                        end
`ifdef GRAY_BIDIR_EN
                    end else if (bin_n == prev_dec) begin
                        prev_d = bin_n;
                        bin_d  = bin_n;
`endif
                    end else begin
                        prev_d  = bin_n;
                        bin_d   = bin_n;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    prev_d  = bin_n;
                    bin_d   = bin_n;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_SYNC;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_SYNC;
            prev_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // prev_dec is only consulted when decrements are accepted.
    logic unused_dec;
    assign unused_dec = ^prev_dec;

    assign Bin_out    = bin_q;
    assign Bin_valid  = valid_q;
    assign Wrap_count = wrap_q;
    assign Ovf_seen   = ovf_q;
    assign Step_err   = err_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker: a default instance plus a CNT_W=2 instance on shared inputs.
// Expectations for the decrement case follow GRAY_BIDIR_EN.
module tb_gray_tracker;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic       Clear;
    logic [2:0] Gray_in;
    logic       Overflow_in;

    logic [2:0] Bin_out,   Bin_out2;
    logic       Bin_valid, Bin_valid2;
    logic [7:0] Wrap_count;
    logic [1:0] Wrap_count2;
    logic       Ovf_seen,  Ovf_seen2;
    logic       Step_err,  Step_err2;

    int checks   = 0;
    int failures = 0;

    gray_tracker #(.WIDTH(3), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Clear(Clear),
        .Gray_in(Gray_in), .Overflow_in(Overflow_in),
        .Bin_out(Bin_out), .Bin_valid(Bin_valid), .Wrap_count(Wrap_count),
        .Ovf_seen(Ovf_seen), .Step_err(Step_err)
    );

    gray_tracker #(.WIDTH(3), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .En(En), .Clear(Clear),
        .Gray_in(Gray_in), .Overflow_in(Overflow_in),
        .Bin_out(Bin_out2), .Bin_valid(Bin_valid2), .Wrap_count(Wrap_count2),
        .Ovf_seen(Ovf_seen2), .Step_err(Step_err2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic [2:0] g, input logic ovf);
        En          = en;
        Clear       = clr;
        Gray_in     = g;
        Overflow_in = ovf;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] b, input logic v,
                           input logic [7:0] w, input logic o, input logic e);
        chk({tag, ".bin"},   32'(Bin_out),    32'(b));
        chk({tag, ".valid"}, 32'(Bin_valid),  32'(v));
        chk({tag, ".wrap"},  32'(Wrap_count), 32'(w));
        chk({tag, ".ovf"},   32'(Ovf_seen),   32'(o));
        chk({tag, ".err"},   32'(Step_err),   32'(e));
    endtask

    initial begin
        logic [2:0] seq_g [9];
        logic [2:0] seq_b [9];
        logic [1:0] sat_w [5];
        logic [2:0] bb;

        seq_g = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        seq_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        sat_w = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        Reset = 1'b0; En = 1'b0; Clear = 1'b0; Gray_in = 3'b000; Overflow_in = 1'b0;
        #3;
        chk_all("reset", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        #20;
        Reset = 1'b1;

        // Disabled: inputs wiggle, nothing may move.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            chk_all("idle", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        end

        // Full count with one wrap.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, seq_g[i], 1'b0);
            chk("count.bin",   32'(Bin_out),   32'(seq_b[i]));
            chk("count.valid", 32'(Bin_valid), 32'd1);
        end
        chk("count.wrap",  32'(Wrap_count),  32'd1);
        chk("count.wrap2", 32'(Wrap_count2), 32'd1);
        chk("count.err",   32'(Step_err),    32'd0);

        // Illegal jump 1->3, stays in error, then Clear and resync.
        step(1'b1, 1'b0, 3'b001, 1'b0);
        chk_all("jump.pre", 3'd1, 1'b1, 8'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b010, 1'b0);
        chk_all("jump", 3'd3, 1'b0, 8'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 3'b110, 1'b0);
        chk_all("jump.after", 3'd4, 1'b0, 8'd1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 3'b111, 1'b0);
        chk_all("jump.clear", 3'd4, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b111, 1'b0);
        chk_all("jump.resync", 3'd5, 1'b1, 8'd0, 1'b0, 1'b0);

        // Held code and sticky overflow.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 3'b011, 1'b0);
            chk_all("hold", 3'd2, 1'b1, 8'd0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 3'b011, 1'b1);
        chk_all("ovf", 3'd2, 1'b1, 8'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        chk_all("ovf.hold", 3'd2, 1'b1, 8'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'b011, 1'b0);
        chk_all("ovf.sticky", 3'd2, 1'b1, 8'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk_all("ovf.clear", 3'd2, 1'b0, 8'd0, 1'b0, 1'b0);

        // Five wraps: 8-bit counter keeps going, 2-bit counter saturates.
        step(1'b1, 1'b0, 3'b000, 1'b0);
        chk("wrap.sync", 32'(Bin_valid), 32'd1);
        for (int w = 0; w < 5; w++) begin
            for (int k = 1; k <= 8; k++) begin
                bb = 3'(k);
                step(1'b1, 1'b0, bb ^ (bb >> 1), 1'b0);
            end
            chk("wrap.cnt8", 32'(Wrap_count),  32'(w + 1));
            chk("wrap.cnt2", 32'(Wrap_count2), 32'(sat_w[w]));
        end
        chk("wrap.err", 32'(Step_err2), 32'd0);
        step(1'b1, 1'b1, 3'b011, 1'b0);
        chk("wrapclr.cnt8", 32'(Wrap_count),  32'd0);
        chk("wrapclr.cnt2", 32'(Wrap_count2), 32'd0);
        chk("wrapclr.valid", 32'(Bin_valid),  32'd0);
        step(1'b1, 1'b0, 3'b101, 1'b0);
        chk_all("wrapclr.sync", 3'd6, 1'b1, 8'd0, 1'b0, 1'b0);

        // Decrement 5->4.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'b111, 1'b0);
        chk("dec.pre", 32'(Bin_out), 32'd5);
        step(1'b1, 1'b0, 3'b110, 1'b0);
`ifdef GRAY_BIDIR_EN
        chk_all("dec", 3'd4, 1'b1, 8'd0, 1'b0, 1'b0);
`else
        chk_all("dec", 3'd4, 1'b0, 8'd0, 1'b0, 1'b1);
`endif

        // Asynchronous reset between clock edges with Bin_out=5.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'b111, 1'b1);
        chk_all("prerst", 3'd5, 1'b1, 8'd0, 1'b1, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("midrst", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("midrst.cnt2", 32'(Wrap_count2), 32'd0);
        #3;
        Reset = 1'b1;
        step(1'b0, 1'b0, 3'b000, 1'b0);
        chk_all("postrst", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
